cpu_fetch_decode_wb: RTL

Control stage wrapped around the 16-bit ALU.
- Fetches instructions from instruction memory over a req/ack handshake, decodes them, and reads an 8x16 register file to drive the ALU operand inputs.
- Writes back the ALU result, holds the architectural n/z/p flags, and owns the instruction pointer (IP), including conditional branches.
- Multi-cycle, one instruction in flight at a time.

---
 rtl/cpu_fetch_decode_wb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cpu_fetch_decode_wb.sv
// Control stage around a 16-bit ALU: fetches over a req/ack handshake, decodes into
// registered ALU operands, then writes back results, flags and the instruction pointer.
module cpu_fetch_decode_wb #(
    parameter logic [15:0] RESET_IP = 16'h0000,
    parameter int          IMM_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] alu_regA,
    output logic [15:0] alu_regB,
    output logic [15:0] alu_imm,
    output logic [15:0] alu_opcode,
    output logic [15:0] alu_IP,
    input  logic [15:0] alu_res,
    input  logic [15:0] alu_next_IP,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_p,
    output logic [2:0]  nzp,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ip;
    logic [15:0] ir;
    logic [15:0] regs [8];
    logic [2:0]  flags;
    logic        armed;

    logic [3:0]  opc;
    logic [2:0]  dst;
    logic [15:0] imm_ext;
    logic        br_taken;
    logic [15:0] br_target;
    logic        wb_en;
    logic        flag_en;
    logic [15:0] wb_data;
    logic [15:0] ip_next;

    assign opc       = ir[15:12];
    assign dst       = ir[11:9];
    assign imem_addr = ip;
    assign nzp       = flags;
    assign imm_ext   = {{(16-IMM_BITS){ir[IMM_BITS-1]}}, ir[IMM_BITS-1:0]};
    assign br_taken  = |(dst & flags);
    assign br_target = ip + 16'd1 + {{7{ir[8]}}, ir[8:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    // armed keeps the request low for the first cycle out of reset so a stale ack is ignored
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = armed;
                if (armed && imem_ack) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC:   state_next = (opc == 4'hF) ? HALT : FETCH;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        wb_en   = 1'b0;
        flag_en = 1'b0;
        wb_data = alu_res;
        ip_next = alu_next_IP;
        case (opc)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9: begin
                wb_en   = 1'b1;
                flag_en = 1'b1;
            end
            4'hA: flag_en = 1'b1;
            4'hB: begin
                wb_en   = 1'b1;
                wb_data = ir[8] ? alu_regB : {8'h00, ir[7:0]};
            end
            4'hC: ip_next = br_taken ? br_target : alu_next_IP;
            4'hF: ip_next = ip;
            default: ;
        endcase
    end

    // LD reg-to-reg uses alu_regB: it was loaded from R[IR[2:0]] in DECODE, before any write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip         <= RESET_IP;
            ir         <= '0;
            flags      <= 3'b010;
            armed      <= 1'b0;
            halted     <= 1'b0;
            alu_regA   <= '0;
            alu_regB   <= '0;
            alu_imm    <= '0;
            alu_opcode <= '0;
            alu_IP     <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                FETCH: begin
                    if (armed && imem_ack) ir <= imem_rdata;
                end
                DECODE: begin
                    alu_regA   <= regs[ir[11:9]];
                    alu_regB   <= regs[ir[2:0]];
                    alu_imm    <= imm_ext;
                    alu_opcode <= ir;
                    alu_IP     <= ip;
                end
                EXEC: begin
                    if (wb_en)   regs[dst] <= wb_data;
                    if (flag_en) flags <= {alu_n, alu_z, alu_p};
                    ip <= ip_next;
                    if (opc == 4'hF) halted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
